huffman_pack_ctrl: RTL and testbench
====================================

HUFFMAN_PACK_CTRL -- requirements
Module: huffman_pack_ctrl

Interface
REQ-001 W, default 8: packed word width and code bus width.
REQ-002 C, default 4: code-width field width.
REQ-003 N, default 4: number of requesters.
REQ-004 TMO, default 16: idle-cycle timeout limit.
REQ-005 clk  in  1  clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  N  per-requester code valid.
REQ-008 req_data  in  N*W  per-requester code, MSB-aligned; only the top req_width bits are significant.
REQ-009 req_width  in  N*C  per-requester code length; the legal range is 1..W.
REQ-010 req_last  in  N  marks the final code of a frame.
REQ-011 req_ready  out  N  per-requester accept.
REQ-012 pk_d  out  W  code to the bit packer, MSB-aligned.
REQ-013 pk_w  out  C  code width to the bit packer.
REQ-014 pk_en  out  1  packer strobe.
REQ-015 grant_id  out  clog2(N)  index of the requester that currently holds the grant.
REQ-016 busy  out  1  high whenever a frame is open.
REQ-017 frame_done  out  1  one-cycle pulse at the end of a frame.
REQ-018 frame_bits  out  16  count of code bits in the frame, excluding padding; held until the next frame starts.
REQ-019 err_width  out  1  sticky flag for an illegal code width.
REQ-020 err_tmo  out  1  sticky timeout flag; present only with HUFF_CTRL_TIMEOUT_EN.

Function
REQ-021 The FSM SHALL have the states IDLE, STREAM and FLUSH.
REQ-022 In IDLE, when any req_valid is high, the block SHALL grant a requester by round-robin, starting with the index after the last granted one, and SHALL enter STREAM in the next cycle.
REQ-023 The grant SHALL be held for the whole frame and SHALL NOT be preempted.
REQ-024 req_ready[grant_id] SHALL be high only in STREAM; all other ready bits SHALL be low.
REQ-025 A transfer occurs when valid and ready are both high; at most one transfer occurs per cycle.
REQ-026 A transfer at cycle t SHALL produce pk_en=1 with pk_d and pk_w registered at t+1, giving a latency of 1.
REQ-027 When no transfer occurs, pk_en SHALL be 0.
REQ-028 A transfer with width 0 or width greater than W SHALL be consumed but not forwarded, and SHALL set err_width.
REQ-029 frame_bits SHALL accumulate the widths of legal codes and SHALL saturate at 0xFFFF.
REQ-030 A mod-W bit counter SHALL track the packer fill level.
REQ-031 A transfer with req_last set SHALL move the FSM to FLUSH, including when that code's width is illegal.
REQ-032 In FLUSH, if fill is not 0, the block SHALL issue exactly one padding strobe with pk_d=0 and pk_w=W-fill.
REQ-033 In FLUSH, if fill is 0, no strobe SHALL be issued.
REQ-034 In every case, FLUSH SHALL pulse frame_done, clear fill and return to IDLE.
REQ-035 req_ready SHALL be low in FLUSH.
REQ-036 A new grant SHALL become possible in the cycle after FLUSH, giving a minimum two-cycle gap between frames.

Reset
REQ-037 Reset SHALL force the following values: state=IDLE, req_ready=0, pk_en=0, pk_d=0, pk_w=0, grant_id=0, busy=0, frame_done=0, frame_bits=0, fill=0, err_width=0 and err_tmo=0.
REQ-038 After reset, the round-robin pointer SHALL give requester 0 first priority.
REQ-039 Reset in the middle of a frame SHALL discard the frame without a flush or frame_done; the packer shares rst.

Configuration
REQ-040 When HUFF_CTRL_TIMEOUT_EN is defined, an idle counter SHALL increment during STREAM while req_valid[grant_id] is low, and SHALL clear on any transfer.
REQ-041 When that counter reaches TMO, the block SHALL set err_tmo and enter FLUSH as if last had been received.
REQ-042 When HUFF_CTRL_TIMEOUT_EN is undefined, the err_tmo port and the counter SHALL be absent, and STREAM SHALL wait for last indefinitely.

Structure
REQ-043 A shared package huff_pkg SHALL hold the FSM state enum, the default W, C and N values, and a width-legality function.
REQ-044 A sub-module rr_arbiter (N-way, one-hot grant with a pointer update on frame end) SHALL implement the grant logic.
REQ-045 The packer SHALL be instantiated externally, not inside this block.

Verification
REQ-046 Requester 1 sends widths 3,5 with last on the second code -> two strobes, frame_bits=8, no pad strobe, frame_done one cycle after the pad decision.
REQ-047 Requester 0 sends widths 3,2 with last -> strobes 3 and 2, then a pad strobe with pk_w=3 and pk_d=0, and frame_bits=5.
REQ-048 Requesters 0, 2 and 3 all hold valid from reset -> grant order 0,2,3,0, with each frame completing before the next grant.
REQ-049 A width-0 code mid-frame -> no strobe for that code, err_width set and stays set, and the frame continues.
REQ-050 HUFF_CTRL_TIMEOUT_EN with TMO=16, and the granted requester drops valid after one width-4 code -> after 16 idle cycles err_tmo=1, a pad strobe with pk_w=4, then frame_done.
REQ-051 rst asserted in STREAM -> on the next cycle all outputs are at reset values, there is no frame_done, and requester 0 is granted first afterwards.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman pack controller: FSM state enum,
// default bus geometry and the code-width legality check.
// Latency: n/a (package). Backpressure: n/a.
package huff_pkg;

    localparam int W_DEF = 8;   // packed word / code bus width
    localparam int C_DEF = 4;   // code-width field width
    localparam int N_DEF = 4;   // number of requesters

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // A code width is usable only if it is non-zero and fits in one word.
    function automatic logic width_ok(input int unsigned w, input int unsigned wmax);
        return (w != 0) && (w <= wmax);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant plus index, search starts at ptr.
// Latency: combinational grant; pointer moves one cycle after upd.
// Backpressure: none; the caller decides when a grant is taken.
// Ports: req (requests), upd/upd_idx (frame ended for upd_idx), gnt/gnt_idx.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          upd,
    input  logic [IW-1:0] upd_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int            k;

    // Scan from the pointer upward, wrapping; first active request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_q) + i) % N;
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end

    // After a frame, priority passes to the requester after the one served.
    always_comb begin
        ptr_d = ptr_q;
        if (upd) begin
            ptr_d = (upd_idx == IW'(N - 1)) ? '0 : upd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/huffman_pack_ctrl.sv
// Frame-level controller feeding an external bit packer from N code requesters.
// Latency: 1 cycle from accepted code to pk_en/pk_d/pk_w; pad strobe 1 cycle after FLUSH.
// Backpressure: valid/ready; only the granted requester sees ready, and only in STREAM.
// Ports: req_* (per-requester code streams), pk_* (packer strobe), grant_id/busy,
// frame_done/frame_bits (frame status), err_width (+ err_tmo).
// Optional: define HUFF_CTRL_TIMEOUT_EN to add the idle timeout and err_tmo port.
module huffman_pack_ctrl
    import huff_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int C   = C_DEF,
    parameter int N   = N_DEF,
    parameter int TMO = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*W-1:0]  req_data,
    input  logic [N*C-1:0]  req_width,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    output logic [W-1:0]    pk_d,
    output logic [C-1:0]    pk_w,
    output logic            pk_en,
    output logic [IW-1:0]   grant_id,
    output logic            busy,
    output logic            frame_done,
    output logic [15:0]     frame_bits,
`ifdef HUFF_CTRL_TIMEOUT_EN
    output logic            err_width,
    output logic            err_tmo
`else
    output logic            err_width
`endif
);

    localparam int FW = (W > 1) ? $clog2(W) : 1;

    state_t        state_q, state_d;
    logic [IW-1:0] gid_q, gid_d;
    logic          pk_en_q, pk_en_d;
    logic [W-1:0]  pk_dat_q, pk_dat_d;
    logic [C-1:0]  pk_wid_q, pk_wid_d;
    logic          frame_done_q, frame_done_d;
    logic [15:0]   frame_bits_q, frame_bits_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          err_width_q, err_width_d;
`ifdef HUFF_CTRL_TIMEOUT_EN
    logic [$clog2(TMO+1)-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                     err_tmo_q, err_tmo_d;
`endif

    logic [N-1:0]  arb_gnt;
    logic [IW-1:0] arb_idx;
    logic          cur_vld, cur_last, xfer, legal;
    logic [W-1:0]  cur_dat;
    logic [C-1:0]  cur_w;
    logic [FW:0]   fill_sum;
    logic [16:0]   bits_sum;

    rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .upd     (state_q == ST_FLUSH),
        .upd_idx (gid_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Granted requester's lane.
    always_comb begin
        cur_vld  = req_valid[gid_q];
        cur_last = req_last[gid_q];
        cur_dat  = req_data[int'(gid_q)*W +: W];
        cur_w    = req_width[int'(gid_q)*C +: C];
        xfer     = (state_q == ST_STREAM) && cur_vld;
        legal    = width_ok(32'(cur_w), W);
        // fill < W and a legal width <= W, so one conditional subtract is a full mod-W.
        fill_sum = {1'b0, fill_q} + (FW+1)'(cur_w);
        bits_sum = {1'b0, frame_bits_q} + 17'(cur_w);
    end

    always_comb begin
        state_d      = state_q;
        gid_d        = gid_q;
        pk_en_d      = 1'b0;
        pk_dat_d     = pk_dat_q;
        pk_wid_d     = pk_wid_q;
        frame_done_d = 1'b0;
        frame_bits_d = frame_bits_q;
        fill_d       = fill_q;
        err_width_d  = err_width_q;
`ifdef HUFF_CTRL_TIMEOUT_EN
        tmo_cnt_d    = '0;
        err_tmo_d    = err_tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    gid_d        = arb_idx;
                    frame_bits_d = '0;
                    state_d      = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (legal) begin
                        pk_en_d      = 1'b1;
                        pk_dat_d     = cur_dat;
                        pk_wid_d     = cur_w;
                        frame_bits_d = bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
                        fill_d       = (fill_sum >= (FW+1)'(W)) ? FW'(fill_sum - (FW+1)'(W))
                                                                : FW'(fill_sum);
                    end else begin
                        err_width_d  = 1'b1;
                    end
                    // An illegal last code still closes the frame.
                    if (cur_last) state_d = ST_FLUSH;
                end
`ifdef HUFF_CTRL_TIMEOUT_EN
                else if (!cur_vld) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (32'(tmo_cnt_q) + 1 >= TMO) begin
                        err_tmo_d = 1'b1;
                        state_d   = ST_FLUSH;
                    end
                end
`endif
            end
            ST_FLUSH: begin
                // Pad the partial word so the packer emits it.
                if (fill_q != '0) begin
                    pk_en_d  = 1'b1;
                    pk_dat_d = '0;
                    pk_wid_d = C'(W - int'(fill_q));
                end
                frame_done_d = 1'b1;
                fill_d       = '0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gid_q        <= '0;
            pk_en_q      <= 1'b0;
            pk_dat_q     <= '0;
            pk_wid_q     <= '0;
            frame_done_q <= 1'b0;
            frame_bits_q <= '0;
            fill_q       <= '0;
            err_width_q  <= 1'b0;
`ifdef HUFF_CTRL_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_tmo_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gid_q        <= gid_d;
            pk_en_q      <= pk_en_d;
            pk_dat_q     <= pk_dat_d;
            pk_wid_q     <= pk_wid_d;
            frame_done_q <= frame_done_d;
            frame_bits_q <= frame_bits_d;
            fill_q       <= fill_d;
            err_width_q  <= err_width_d;
`ifdef HUFF_CTRL_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            err_tmo_q    <= err_tmo_d;
`endif
        end
    end

    assign req_ready  = (state_q == ST_STREAM) ? (N'(1) << gid_q) : '0;
    assign pk_en      = pk_en_q;
    assign pk_d       = pk_dat_q;
    assign pk_w       = pk_wid_q;
    assign grant_id   = gid_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign frame_bits = frame_bits_q;
    assign err_width  = err_width_q;
`ifdef HUFF_CTRL_TIMEOUT_EN
    assign err_tmo    = err_tmo_q;
`endif

endmodule

// File: tb/tb_huffman_pack_ctrl.sv
// Directed bench for huffman_pack_ctrl (W=8, C=4, N=4, TMO=16).
// Inputs are driven 1 ns after each rising edge; outputs are checked at that point.
module tb_huffman_pack_ctrl;

    localparam int W = 8;
    localparam int C = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N*C-1:0] req_width;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   pk_d;
    logic [C-1:0]   pk_w;
    logic           pk_en;
    logic [1:0]     grant_id;
    logic           busy;
    logic           frame_done;
    logic [15:0]    frame_bits;
    logic           err_width;
`ifdef HUFF_CTRL_TIMEOUT_EN
    logic           err_tmo;
`endif

    int total  = 0;
    int passed = 0;

    huffman_pack_ctrl #(.W(W), .C(C), .N(N), .TMO(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_width  (req_width),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .pk_d       (pk_d),
        .pk_w       (pk_w),
        .pk_en      (pk_en),
        .grant_id   (grant_id),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_bits (frame_bits),
`ifdef HUFF_CTRL_TIMEOUT_EN
        .err_width  (err_width),
        .err_tmo    (err_tmo)
`else
        .err_width  (err_width)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input int i, input logic v, input logic [W-1:0] d,
                         input logic [C-1:0] w, input logic l);
        req_valid[i]       = v;
        req_data[i*W +: W] = d;
        req_width[i*C +: C] = w;
        req_last[i]        = l;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_data  = '0;
        req_width = '0;
        req_last  = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_pk_en"}, 32'(pk_en), 32'h0);
        chk({tag, "_pk_d"},  32'(pk_d), 32'h0);
        chk({tag, "_pk_w"},  32'(pk_w), 32'h0);
        chk({tag, "_gid"},   32'(grant_id), 32'h0);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_done"},  32'(frame_done), 32'h0);
        chk({tag, "_bits"},  32'(frame_bits), 32'h0);
        chk({tag, "_errw"},  32'(err_width), 32'h0);
`ifdef HUFF_CTRL_TIMEOUT_EN
        chk({tag, "_errt"},  32'(err_tmo), 32'h0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        tick(); tick();
        chk_reset_outs("rst");
        rst = 1'b0;

        // Frame 1: requester 1, widths 3 then 5 (last) -> fill ends at 0, no pad.
        drive(1, 1'b1, 8'hA0, 4'd3, 1'b0);
        tick();
        chk("a_gid",   32'(grant_id), 32'd1);
        chk("a_busy",  32'(busy), 32'd1);
        chk("a_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("a_en1", 32'(pk_en), 32'd1);
        chk("a_w1",  32'(pk_w), 32'd3);
        chk("a_d1",  32'(pk_d), 32'hA0);
        drive(1, 1'b1, 8'hD8, 4'd5, 1'b1);
        tick();
        chk("a_en2",    32'(pk_en), 32'd1);
        chk("a_w2",     32'(pk_w), 32'd5);
        chk("a_d2",     32'(pk_d), 32'hD8);
        chk("a_flush_ready", 32'(req_ready), 32'h0);
        clear_reqs();
        tick();
        chk("a_nopad", 32'(pk_en), 32'd0);
        chk("a_done",  32'(frame_done), 32'd1);
        chk("a_bits",  32'(frame_bits), 32'd8);
        chk("a_idle",  32'(busy), 32'd0);
        tick();
        chk("a_done_pulse", 32'(frame_done), 32'd0);
        chk("a_bits_hold",  32'(frame_bits), 32'd8);

        // Frame 2: requester 0, widths 3,2 (last) -> fill 5, pad of 3.
        drive(0, 1'b1, 8'hE0, 4'd3, 1'b0);
        tick();
        chk("b_gid", 32'(grant_id), 32'd0);
        tick();
        chk("b_w1", 32'(pk_w), 32'd3);
        drive(0, 1'b1, 8'hC0, 4'd2, 1'b1);
        tick();
        chk("b_w2", 32'(pk_w), 32'd2);
        chk("b_d2", 32'(pk_d), 32'hC0);
        clear_reqs();
        tick();
        chk("b_pad_en", 32'(pk_en), 32'd1);
        chk("b_pad_w",  32'(pk_w), 32'd3);
        chk("b_pad_d",  32'(pk_d), 32'h00);
        chk("b_done",   32'(frame_done), 32'd1);
        chk("b_bits",   32'(frame_bits), 32'd5);
        tick();
        chk("b_after_pad", 32'(pk_en), 32'd0);

        // Frame 3: requester 2, widths 4, 0 (illegal), 4 (last).
        drive(2, 1'b1, 8'hF0, 4'd4, 1'b0);
        tick();
        chk("c_gid", 32'(grant_id), 32'd2);
        tick();
        chk("c_en1", 32'(pk_en), 32'd1);
        drive(2, 1'b1, 8'hFF, 4'd0, 1'b0);
        tick();
        chk("c_w0_no_strobe", 32'(pk_en), 32'd0);
        chk("c_errw",         32'(err_width), 32'd1);
        drive(2, 1'b1, 8'h90, 4'd4, 1'b1);
        tick();
        chk("c_en3",       32'(pk_en), 32'd1);
        chk("c_d3",        32'(pk_d), 32'h90);
        chk("c_errw_hold", 32'(err_width), 32'd1);
        clear_reqs();
        tick();
        chk("c_done", 32'(frame_done), 32'd1);
        chk("c_bits", 32'(frame_bits), 32'd8);
        chk("c_nopad", 32'(pk_en), 32'd0);

        // Round robin from reset with 0, 2, 3 holding valid: order 0,2,3,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("d_errw_cleared", 32'(err_width), 32'd0);
        drive(0, 1'b1, 8'h11, 4'd8, 1'b1);
        drive(2, 1'b1, 8'h22, 4'd8, 1'b1);
        drive(3, 1'b1, 8'h33, 4'd8, 1'b1);
        begin
            logic [1:0] order [4];
            logic [7:0] dats  [4];
            order = '{2'd0, 2'd2, 2'd3, 2'd0};
            dats  = '{8'h11, 8'h22, 8'h33, 8'h11};
            for (int f = 0; f < 4; f++) begin
                tick();
                chk($sformatf("d_gid%0d", f),   32'(grant_id), 32'(order[f]));
                chk($sformatf("d_ready%0d", f), 32'(req_ready), 32'(4'b0001 << order[f]));
                tick();
                chk($sformatf("d_d%0d", f), 32'(pk_d), 32'(dats[f]));
                if (f == 3) clear_reqs();
                tick();
                chk($sformatf("d_done%0d", f), 32'(frame_done), 32'd1);
                chk($sformatf("d_idle%0d", f), 32'(busy), 32'd0);
            end
        end

        // Illegal-width last code still closes the frame (requester 1 now first).
        drive(1, 1'b1, 8'h80, 4'd9, 1'b1);
        tick();
        chk("e_gid", 32'(grant_id), 32'd1);
        tick();
        clear_reqs();
        chk("e_no_strobe", 32'(pk_en), 32'd0);
        chk("e_errw",      32'(err_width), 32'd1);
        chk("e_flush",     32'(req_ready), 32'h0);
        chk("e_busy",      32'(busy), 32'd1);
        tick();
        chk("e_done", 32'(frame_done), 32'd1);
        chk("e_bits", 32'(frame_bits), 32'd0);

        // Reset in STREAM discards the frame; requester 0 wins afterwards.
        drive(3, 1'b1, 8'hC0, 4'd2, 1'b0);
        tick();
        chk("f_gid", 32'(grant_id), 32'd3);
        tick();
        chk("f_en", 32'(pk_en), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_outs("f_rst");
        rst = 1'b0;
        drive(0, 1'b1, 8'hA0, 4'd3, 1'b0);
        tick();
        chk("f_no_done", 32'(frame_done), 32'd0);
        chk("f_gid0",    32'(grant_id), 32'd0);
        chk("f_busy",    32'(busy), 32'd1);

`ifdef HUFF_CTRL_TIMEOUT_EN
        // Timeout: one width-4 code, then requester 0 goes quiet.
        rst = 1'b1;
        clear_reqs();
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 8'hF0, 4'd4, 1'b0);
        tick();
        tick();
        chk("t_en", 32'(pk_en), 32'd1);
        clear_reqs();
        for (int i = 0; i < 15; i++) tick();
        chk("t_not_yet", 32'(err_tmo), 32'd0);
        tick();
        chk("t_errt",  32'(err_tmo), 32'd1);
        chk("t_flush", 32'(req_ready), 32'h0);
        tick();
        chk("t_pad_en", 32'(pk_en), 32'd1);
        chk("t_pad_w",  32'(pk_w), 32'd4);
        chk("t_done",   32'(frame_done), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
